// File: rtl/sift_pkg.sv
// ============================================================================
// Module   : sift_pkg
// Purpose  : Shared geometry constants and state encoding for the SIFT
//            blur / DoG pipeline stages.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sift_pkg;

  localparam int PIX_W     = 8;
  localparam int ROW_PIX   = 640;
  localparam int ROWS      = 481;
  localparam int ADDR_W    = 9;

  // One SRAM word holds a whole image row
  localparam int ROW_W     = ROW_PIX * PIX_W;
  // DoG pixels carry one extra bit for the sign
  localparam int DOG_ROW_W = ROW_PIX * (PIX_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dog_state_e;

endpackage

`default_nettype wire

// File: rtl/dog_row_engine_if.sv
// ============================================================================
// Module   : dog_row_engine_if
// Purpose  : Start/done handshake plus the blur-read and DoG-write SRAM
//            buses of the DoG row engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dog_row_engine_if #(
  parameter int PIX_W   = sift_pkg::PIX_W,
  parameter int ROW_PIX = sift_pkg::ROW_PIX,
  parameter int ADDR_W  = sift_pkg::ADDR_W
);
  import sift_pkg::*;

  logic                           start;
  logic                           done;
  logic                           busy;
  logic [ADDR_W-1:0]              blur_addr;
  logic                           blur_re;
  logic [ROW_PIX*PIX_W-1:0]       blur_dout_a;
  logic [ROW_PIX*PIX_W-1:0]       blur_dout_b;
  logic                           dog_we;
  logic [ADDR_W-1:0]              dog_addr;
  logic [ROW_PIX*(PIX_W+1)-1:0]   dog_din;

  // Engine side
  modport master (
    input  start, blur_dout_a, blur_dout_b,
    output done, busy, blur_addr, blur_re, dog_we, dog_addr, dog_din
  );

  // Controller / SRAM side
  modport slave (
    output start, blur_dout_a, blur_dout_b,
    input  done, busy, blur_addr, blur_re, dog_we, dog_addr, dog_din
  );

endinterface

`default_nettype wire

// File: rtl/dog_row_sub.sv
// ============================================================================
// Module   : dog_row_sub
// Purpose  : Combinational row-wide subtractor, dog[i] = b[i] - a[i] as a
//            (PIX_W+1)-bit two's complement value (always exact).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dog_row_sub #(
  parameter int PIX_W   = sift_pkg::PIX_W,
  parameter int ROW_PIX = sift_pkg::ROW_PIX
) (
  input  logic [ROW_PIX*PIX_W-1:0]     a_i,
  input  logic [ROW_PIX*PIX_W-1:0]     b_i,
  output logic [ROW_PIX*(PIX_W+1)-1:0] dog_o
);
  import sift_pkg::*;

  // Zero-extending both operands by one bit makes the difference exact
  for (genvar gi = 0; gi < ROW_PIX; gi++) begin : g_pix
    assign dog_o[gi*(PIX_W+1) +: PIX_W+1] =
      {1'b0, b_i[gi*PIX_W +: PIX_W]} - {1'b0, a_i[gi*PIX_W +: PIX_W]};
  end

endmodule

`default_nettype wire

// File: rtl/dog_row_engine.sv
// ============================================================================
// Module   : dog_row_engine
// Purpose  : Streams two blur SRAMs row by row, subtracts them pixel-wise and
//            writes each signed difference row into the DoG SRAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dog_row_engine #(
  parameter int PIX_W   = sift_pkg::PIX_W,
  parameter int ROW_PIX = sift_pkg::ROW_PIX,
  parameter int ROWS    = sift_pkg::ROWS,
  parameter int ADDR_W  = sift_pkg::ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  dog_row_engine_if.master bus
);
  import sift_pkg::*;

  localparam int                DOG_W     = ROW_PIX * (PIX_W + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS - 1);

  dog_state_e        state_q;
  logic              busy_q;
  logic              done_q;
  logic              re_q;
  logic [ADDR_W-1:0] raddr_q;
  // Stage 1: SRAM data valid; stage 2: registered difference / write
  logic              v1_q;
  logic [ADDR_W-1:0] a1_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DOG_W-1:0]  din_q;
  logic [DOG_W-1:0]  din_d;

  dog_row_sub #(
    .PIX_W   (PIX_W),
    .ROW_PIX (ROW_PIX)
  ) u_sub (
    .a_i   (bus.blur_dout_a),
    .b_i   (bus.blur_dout_b),
    .dog_o (din_d)
  );

  // Control FSM: read-address sequencing, done pulse and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      re_q    <= 1'b0;
      raddr_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            re_q    <= 1'b1;
            raddr_q <= '0;
          end
        end
        RUN: begin
          // Address saturates at the last row; reads stop after it
          if (raddr_q == LAST_ADDR) begin
            state_q <= DRAIN;
            re_q    <= 1'b0;
          end else begin
            raddr_q <= raddr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (we_q && (waddr_q == LAST_ADDR)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage valid/address pipeline matching the SRAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      din_q   <= '0;
    end else begin
      v1_q    <= re_q;
      a1_q    <= raddr_q;
      we_q    <= v1_q;
      waddr_q <= a1_q;
      // Hold the last row between writes
      if (v1_q) begin
        din_q <= din_d;
      end
    end
  end

  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.blur_re   = re_q;
  assign bus.blur_addr = raddr_q;
  assign bus.dog_we    = we_q;
  assign bus.dog_addr  = waddr_q;
  assign bus.dog_din   = din_q;

endmodule

`default_nettype wire
